// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: framing constants, command/response codes, parser
// states and the command-to-response lookup.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  localparam logic [7:0] CMD_PING   = 8'h01;
  localparam logic [7:0] CMD_STATUS = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h10;

  localparam logic [7:0] RSP_PING    = 8'hFF;
  localparam logic [7:0] RSP_STATUS  = 8'hFE;
  localparam logic [7:0] RSP_CRC_ERR = 8'hFD;
  localparam logic [7:0] RSP_CMD_ERR = 8'hFC;
  localparam logic [7:0] RSP_OK      = 8'hFB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CRC,
    S_CHECK,
    S_COMMIT,
    S_RESP
  } state_t;

  function automatic logic [7:0] rsp_for(
    input logic [7:0] cmd
  );
    logic [7:0] r;
    r = RSP_CMD_ERR;
    unique case (1'b1)
      cmd == CMD_PING:   r = RSP_PING;
      cmd == CMD_STATUS: r = RSP_STATUS;
      cmd == CMD_WRITE:  r = RSP_OK;
      default:           r = RSP_CMD_ERR;
    endcase
    return r;
  endfunction

  function automatic logic is_known(
    input logic [7:0] cmd
  );
    return rsp_for(cmd) != RSP_CMD_ERR;
  endfunction

endpackage

// File: rtl/crc8_step.sv
// crc8_step: one-byte CRC-8 update, MSB first, no reflection.
module crc8_step
  import uart_cmd_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  always_comb begin
    crc_next = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[7])
        crc_next = {crc_next[6:0], 1'b0} ^ CRC_POLY;
      else
        crc_next = {crc_next[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames, CRC-checks and commits UART commands.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int WR_GAP      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       pl_we,
  output logic [7:0] pl_addr,
  output logic [7:0] pl_data,
  output logic [7:0] cmd_code,
  output logic       cmd_valid,
  output logic       wr,
  output logic [7:0] msg,
  output logic       rx_drop
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = $clog2(WR_GAP + 1);

  state_t state, state_d;
  logic [7:0] cmd_r, cmd_d;
  logic [7:0] len_r, len_d;
  logic [7:0] idx_r, idx_d;
  logic [7:0] crc_r, crc_d;
  logic [7:0] nxt_r, nxt_d;
  logic       crc_ok_r, crc_ok_d;
  logic [GW-1:0] gap_r, gap_d;

  logic       pl_we_d, cmd_valid_d;
  logic       wr_d, rx_drop_d;
  logic [7:0] pl_addr_d, pl_data_d;
  logic [7:0] cmd_code_d, msg_d;

  logic       resp_go;
  logic [7:0] resp_code;
  logic [7:0] crc_nx;
  logic       gap_ok;
  logic       tmo_hit;
  logic [7:0] pl_buf [2**AW];

  crc8_step u_crc (
    .crc      (crc_r),
    .data     (rx_data),
    .crc_next (crc_nx)
  );

  // Gap is judged at the cycle the new wr would become visible.
  assign gap_ok = gap_r >= GW'(WR_GAP - 1);

`ifdef UART_CMD_TIMEOUT_EN
  logic        in_frame;
  logic [31:0] tmo_r;

  assign in_frame = state inside
    {S_CMD, S_LEN, S_PAYLOAD, S_CRC};
  assign tmo_hit = in_frame && !rx_valid &&
    (tmo_r == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_valid)
      tmo_r <= '0;
    else
      tmo_r <= tmo_r + 32'd1;
  end
`else
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_valid)
      pl_buf[idx_r[AW-1:0]] <= rx_data;
  end

  always_comb begin
    state_d     = state;
    cmd_d       = cmd_r;
    len_d       = len_r;
    idx_d       = idx_r;
    crc_d       = crc_r;
    nxt_d       = nxt_r;
    crc_ok_d    = crc_ok_r;
    pl_we_d     = 1'b0;
    pl_addr_d   = pl_addr;
    pl_data_d   = pl_data;
    cmd_code_d  = cmd_code;
    cmd_valid_d = 1'b0;
    wr_d        = 1'b0;
    msg_d       = msg;
    rx_drop_d   = 1'b0;
    resp_go     = 1'b0;
    resp_code   = nxt_r;
    unique case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          crc_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          crc_d   = crc_nx;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_d = rx_data;
          crc_d = crc_nx;
          idx_d = '0;
          if (rx_data > 8'(MAX_LEN)) begin
            resp_go   = 1'b1;
            resp_code = RSP_CMD_ERR;
          end else if (rx_data == 8'd0) begin
            state_d = S_CRC;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          crc_d = crc_nx;
          idx_d = idx_r + 8'd1;
          if (idx_r == len_r - 8'd1)
            state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          crc_ok_d = (rx_data == crc_r);
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        rx_drop_d = rx_valid;
        if (!crc_ok_r) begin
          resp_go   = 1'b1;
          resp_code = RSP_CRC_ERR;
        end else if (!is_known(cmd_r)) begin
          resp_go   = 1'b1;
          resp_code = RSP_CMD_ERR;
        end else if (len_r == 8'd0) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = cmd_r;
          resp_go     = 1'b1;
          resp_code   = rsp_for(cmd_r);
        end else begin
          // First byte leaves here so commit starts a cycle earlier.
          pl_we_d   = 1'b1;
          pl_addr_d = 8'd0;
          pl_data_d = pl_buf[0];
          idx_d     = 8'd1;
          nxt_d     = rsp_for(cmd_r);
          state_d   = S_COMMIT;
        end
      end
      S_COMMIT: begin
        rx_drop_d = rx_valid;
        if (idx_r < len_r) begin
          pl_we_d   = 1'b1;
          pl_addr_d = idx_r;
          pl_data_d = pl_buf[idx_r[AW-1:0]];
          idx_d     = idx_r + 8'd1;
        end else begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = cmd_r;
          resp_go     = 1'b1;
        end
      end
      S_RESP: begin
        rx_drop_d = rx_valid;
        resp_go   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (resp_go) begin
      if (gap_ok) begin
        wr_d    = 1'b1;
        msg_d   = resp_code;
        state_d = S_IDLE;
      end else begin
        nxt_d   = resp_code;
        state_d = S_RESP;
      end
    end
    if (tmo_hit)
      state_d = S_IDLE;

    gap_d = gap_r;
    if (wr_d)
      gap_d = '0;
    else if (gap_r < GW'(WR_GAP))
      gap_d = gap_r + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_r     <= '0;
      len_r     <= '0;
      idx_r     <= '0;
      crc_r     <= '0;
      nxt_r     <= '0;
      crc_ok_r  <= 1'b0;
      gap_r     <= GW'(WR_GAP);
      pl_we     <= 1'b0;
      pl_addr   <= '0;
      pl_data   <= '0;
      cmd_code  <= '0;
      cmd_valid <= 1'b0;
      wr        <= 1'b0;
      msg       <= '0;
      rx_drop   <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_r     <= cmd_d;
      len_r     <= len_d;
      idx_r     <= idx_d;
      crc_r     <= crc_d;
      nxt_r     <= nxt_d;
      crc_ok_r  <= crc_ok_d;
      gap_r     <= gap_d;
      pl_we     <= pl_we_d;
      pl_addr   <= pl_addr_d;
      pl_data   <= pl_data_d;
      cmd_code  <= cmd_code_d;
      cmd_valid <= cmd_valid_d;
      wr        <= wr_d;
      msg       <= msg_d;
      rx_drop   <= rx_drop_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: random and directed frames against a byte-level
// frame model; a negedge monitor scores every strobe it sees.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 200;
  localparam int GAP     = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       pl_we, cmd_valid, wr, rx_drop;
  logic [7:0] pl_addr, pl_data, cmd_code, msg;

  uart_cmd_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO),
    .WR_GAP      (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pl_we     (pl_we),
    .pl_addr   (pl_addr),
    .pl_data   (pl_data),
    .cmd_code  (cmd_code),
    .cmd_valid (cmd_valid),
    .wr        (wr),
    .msg       (msg),
    .rx_drop   (rx_drop)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_pl[$];
  logic [7:0]  exp_cv[$];
  logic [7:0]  exp_wr[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_drop = 0;
  int drop_seen = 0;
  int cyc = 0;
  int last_wr = 0;
  int last_gap = 0;
  bit have_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic spurious(string name, int act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h, nothing expected", name, act);
  endtask

  always @(negedge clk) begin
    if (pl_we) begin
      if (exp_pl.size() == 0)
        spurious("pl_we", {pl_addr, pl_data});
      else
        check("pl addr/data", {pl_addr, pl_data},
              exp_pl.pop_front());
    end
    if (cmd_valid) begin
      if (exp_cv.size() == 0)
        spurious("cmd_valid", cmd_code);
      else
        check("cmd_code", cmd_code, exp_cv.pop_front());
    end
    if (wr) begin
      if (have_last) begin
        n_cmp++;
        if (cyc - last_wr < GAP) begin
          n_err++;
          $display("FAIL wr gap: got %0d, want >= %0d",
                   cyc - last_wr, GAP);
        end
      end
      last_gap  = cyc - last_wr;
      last_wr   = cyc;
      have_last = 1'b1;
      if (exp_wr.size() == 0)
        spurious("wr", msg);
      else
        check("msg", msg, exp_wr.pop_front());
    end
    if (rx_drop) drop_seen++;
    if (rst) begin
      have_last = 1'b0;
      exp_pl.delete();
      exp_cv.delete();
      exp_wr.delete();
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] crc8(logic [7:0] q[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (q[i]) begin
      c = c ^ q[i];
      repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_crc(
    logic [7:0] cmd, int len, logic [7:0] pl[$]
  );
    logic [7:0] q[$];
    q = {cmd, 8'(len)};
    foreach (pl[i]) q.push_back(pl[i]);
    return crc8(q);
  endfunction

  function automatic logic [7:0] model_rsp(logic [7:0] cmd);
    case (cmd)
      8'h01:   return 8'hFF;
      8'h02:   return 8'hFE;
      8'h10:   return 8'hFB;
      default: return 8'hFC;
    endcase
  endfunction

  // Model: decide the whole frame's outcome up front, then send it.
  task automatic send_frame(
    logic [7:0] cmd, int len, logic [7:0] pl[$],
    logic [7:0] crc_byte, bit gaps, int drop_dly
  );
    bit crc_good;
    crc_good = (crc_byte == frame_crc(cmd, len, pl));
    if (len > MAX_LEN) begin
      exp_wr.push_back(8'hFC);
    end else if (!crc_good) begin
      exp_wr.push_back(8'hFD);
    end else if (model_rsp(cmd) == 8'hFC) begin
      exp_wr.push_back(8'hFC);
    end else begin
      for (int i = 0; i < len; i++)
        exp_pl.push_back({8'(i), pl[i]});
      exp_cv.push_back(cmd);
      exp_wr.push_back(model_rsp(cmd));
    end
    send(8'hA5);
    if (gaps) tick($urandom_range(0, 2));
    send(cmd);
    if (gaps) tick($urandom_range(0, 2));
    send(8'(len));
    if (len > MAX_LEN) return;
    for (int i = 0; i < len; i++) begin
      if (gaps) tick($urandom_range(0, 2));
      send(pl[i]);
    end
    if (gaps) tick($urandom_range(0, 2));
    send(crc_byte);
    if (drop_dly >= 0) begin
      tick(drop_dly);
      send(8'($urandom));
      exp_drop++;
    end
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    while (exp_wr.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (exp_wr.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d responses pending after %0d cycles",
               tag, exp_wr.size(), n);
    end
    tick(2);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] cmd, b;
    int len;
    logic [7:0] flip;

    tick(3);
    @(negedge clk);
    check("rst pl_we", pl_we, 0);
    check("rst pl_addr", pl_addr, 0);
    check("rst pl_data", pl_data, 0);
    check("rst cmd_code", cmd_code, 0);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst wr", wr, 0);
    check("rst msg", msg, 0);
    check("rst rx_drop", rx_drop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    pl = {};
    send_frame(8'h01, 0, pl, 8'h15, 1'b0, -1);
    wait_idle("ping");

    pl = {8'h12, 8'h34};
    send_frame(8'h10, 2, pl, frame_crc(8'h10, 2, pl), 1'b0, 0);
    wait_idle("write");

    send_frame(8'h10, 2, pl, frame_crc(8'h10, 2, pl) ^ 8'h01,
               1'b0, 0);
    wait_idle("bad crc");

    pl = {};
    send_frame(8'h10, MAX_LEN + 1, pl, 8'h00, 1'b0, -1);
    wait_idle("oversize");

    pl = {8'h5A};
    send_frame(8'h7E, 1, pl, frame_crc(8'h7E, 1, pl), 1'b0, 0);
    wait_idle("unknown cmd");

    pl = {};
    send_frame(8'h02, MAX_LEN, pl, 8'h00, 1'b0, -1);
    wait_idle("max len");

    tick(GAP);
    pl = {};
    send_frame(8'h01, 0, pl, 8'h15, 1'b0, -1);
    tick(3);
    send_frame(8'h01, 0, pl, 8'h15, 1'b0, 5);
    wait_idle("back-to-back");
    check("b2b wr spacing", last_gap, GAP);

    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    send_frame(8'h10, 8, pl, frame_crc(8'h10, 8, pl), 1'b0, -1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("first pl_we latency", pl_we, 1);
    check("first pl_addr", pl_addr, 0);
    @(posedge clk);
    #1;
    check("pl_we after rst", pl_we, 0);
    rst = 1'b0;
    tick(GAP + 10);

`ifdef UART_CMD_TIMEOUT_EN
    send(8'hA5);
    send(8'h10);
    tick(TMO + 5);
    pl = {};
    send_frame(8'h01, 0, pl, 8'h15, 1'b0, -1);
    wait_idle("after timeout");
`endif

    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send(b);
      end
      case ($urandom_range(0, 4))
        0:       cmd = 8'h01;
        1:       cmd = 8'h02;
        2, 3:    cmd = 8'h10;
        default: cmd = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0)
        len = $urandom_range(MAX_LEN + 1, 255);
      else
        len = $urandom_range(0, MAX_LEN);
      pl = {};
      if (len <= MAX_LEN)
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      flip = ($urandom_range(0, 4) == 0) ?
             8'($urandom_range(1, 255)) : 8'h00;
      send_frame(cmd, len, pl, frame_crc(cmd, len, pl) ^ flip,
                 1'b1, ($urandom_range(0, 2) == 0) ? 0 : -1);
      wait_idle("random frame");
    end

    tick(5);
    check("pl left", exp_pl.size(), 0);
    check("cmd_valid left", exp_cv.size(), 0);
    check("rx_drop count", drop_seen, exp_drop);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
